// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 16x tick, LSB first; optional even parity bit via UART_TX_PARITY_EN
module uart_tx #(
  parameter int NB_BITS = 8,
  parameter int SB_TICK = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_BITS-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_busy
);

  localparam int            BW       = (NB_BITS > 1) ? $clog2(NB_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(NB_BITS - 1);
  localparam logic [4:0]    BIT_END  = 5'd15;
  localparam logic [4:0]    STOP_END = 5'(SB_TICK - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;

  logic parity_q, parity_d;
`endif

  logic [2:0]         state_q, state_d;
  logic [4:0]         tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NB_BITS-1:0] shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_tx_start) begin
          shift_d = i_data;
          tick_d  = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^i_data;
`endif
        end
      end
      START: begin
        if (i_tick) begin
          if (tick_q == BIT_END) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (tick_q == BIT_END) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (i_tick) begin
          if (tick_q == BIT_END) begin
            tick_d  = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (i_tick) begin
          if (tick_q == STOP_END) begin
            tick_d  = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so o_tx can be a plain flop.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_done = done_q;
  assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx; a line monitor decodes frames against a scoreboard queue
module tb_uart_tx;

  localparam int NB = 8;
  localparam int SB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_TICKS = (1 + NB) * 16 + SB + 16 * PAR;
  localparam int NSLOT       = 1 + NB + PAR + 1;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_tick;
  logic          i_tx_start;
  logic [NB-1:0] i_data;
  logic          o_tx;
  logic          o_tx_done;
  logic          o_busy;

  uart_tx #(.NB_BITS(NB), .SB_TICK(SB)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tick     (i_tick),
    .i_tx_start (i_tx_start),
    .i_data     (i_data),
    .o_tx       (o_tx),
    .o_tx_done  (o_tx_done),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int errors    = 0;
  int checks    = 0;
  int cyc       = 0;
  int tick_per  = 1;
  int tick_ph   = 0;
  int done_cnt  = 0;
  int exp_done  = 0;
  int abort_cnt = 0;
  logic [NB-1:0] exp_q[$];

  int            m_cnt;
  int            m_start = 0;
  int            m_seen_abort = 0;
  int            m_k;
  logic          m_prev = 1'b1;
  logic          m_active = 1'b0;
  logic          m_busy_low;
  logic [NB-1:0] m_word;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Tick generator; drives the value the DUT samples at the next edge
  initial begin
    i_tick = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (tick_per <= 1) begin
        i_tick = 1'b1;
      end else begin
        i_tick  = (tick_ph == 0);
        tick_ph = (tick_ph + 1) % tick_per;
      end
    end
  end

  // Line monitor: samples each bit at its middle and pops the scoreboard at the stop bit
  initial begin
    forever begin
      @(negedge i_clk);
      if (abort_cnt != m_seen_abort) begin
        m_seen_abort = abort_cnt;
        m_active     = 1'b0;
      end
      if (o_tx_done === 1'b1) begin
        done_cnt++;
        check_eq("frame_len", cyc - m_start, FRAME_TICKS * tick_per);
      end
      if (!m_active && m_prev === 1'b1 && o_tx === 1'b0) begin
        m_active   = 1'b1;
        m_cnt      = 0;
        m_start    = cyc;
        m_word     = '0;
        m_busy_low = 1'b0;
      end
      if (m_active) begin
        if (o_busy !== 1'b1) m_busy_low = 1'b1;
        if (m_cnt >= 8 * tick_per && (m_cnt - 8 * tick_per) % (16 * tick_per) == 0) begin
          m_k = (m_cnt - 8 * tick_per) / (16 * tick_per);
          if (m_k == 0) begin
            check_eq("start_bit", o_tx, 0);
          end else if (m_k <= NB) begin
            m_word[m_k-1] = o_tx;
          end else if (m_k == NSLOT - 1) begin
            check_eq("stop_bit", o_tx, 1);
            check_eq("busy_in_frame", m_busy_low, 0);
            check_eq("frame_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_eq("data", m_word, exp_q.pop_front());
            m_active = 1'b0;
          end else begin
            check_eq("parity_bit", o_tx, (exp_q.size() > 0) ? ^exp_q[0] : 1'b0);
          end
        end
        m_cnt++;
      end
      m_prev = o_tx;
    end
  end

  task automatic send(input logic [NB-1:0] d, input bit push);
    int n;
    n = 0;
    @(posedge i_clk); #2;
    while ((o_busy !== 1'b0 || i_tick !== 1'b1) && n < 1000) begin
      @(posedge i_clk); #2;
      n++;
    end
    check_eq("send_ready", n < 1000, 1);
    i_data     = d;
    i_tx_start = 1'b1;
    if (push) begin
      exp_q.push_back(d);
      exp_done++;
    end
    @(posedge i_clk); #2;
    i_tx_start = 1'b0;
    check_eq("accept_latency", {o_busy, o_tx}, 2'b10);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge i_clk);
    while (o_tx_done !== 1'b1 && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check_eq("done_timeout", n < budget, 1);
    repeat (4) @(posedge i_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst      = 1'b1;
    i_tx_start = 1'b0;
    i_data     = '0;
    repeat (3) @(posedge i_clk);
    #2;
    check_eq("rst_tx", o_tx, 1);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_done", o_tx_done, 0);
    i_rst = 1'b0;

    // Single frame, tick every cycle
    send(8'hA5, 1);
    wait_done(400);
    check_eq("done_single", done_cnt, exp_done);

    // Slow tick: one tick every 4 clocks
    tick_per = 4;
    repeat (8) @(posedge i_clk);
    send(8'h3C, 1);
    wait_done(2000);
    check_eq("done_slow", done_cnt, exp_done);
    tick_per = 1;
    repeat (8) @(posedge i_clk);

    // Start request while busy is dropped
    send(8'h55, 1);
    repeat (39) @(posedge i_clk);
    #2;
    i_data     = 8'hFF;
    i_tx_start = 1'b1;
    @(posedge i_clk); #2;
    i_tx_start = 1'b0;
    wait_done(400);
    repeat (300) @(posedge i_clk);
    check_eq("done_busy_ignored", done_cnt, exp_done);
    check_eq("idle_after_busy", o_busy, 0);

    // Back-to-back frames with start held high
    @(posedge i_clk); #2;
    i_data     = 8'h01;
    i_tx_start = 1'b1;
    exp_q.push_back(8'h01);
    exp_done++;
    begin
      int n;
      n = 0;
      @(negedge i_clk);
      while (o_tx_done !== 1'b1 && n < 400) begin
        @(negedge i_clk);
        n++;
      end
      check_eq("b2b_first_done", n < 400, 1);
    end
    i_data = 8'h80;
    exp_q.push_back(8'h80);
    exp_done++;
    @(posedge i_clk); #2;
    i_tx_start = 1'b0;
    check_eq("b2b_gap", {o_busy, o_tx}, 2'b10);
    wait_done(400);
    check_eq("done_b2b", done_cnt, exp_done);

    // Reset during the 4th data bit aborts the frame
    send(8'h00, 0);
    repeat (71) @(posedge i_clk);
    #2;
    abort_cnt++;
    i_rst = 1'b1;
    @(posedge i_clk); #2;
    i_rst = 1'b0;
    check_eq("abort_tx", o_tx, 1);
    check_eq("abort_busy", o_busy, 0);
    repeat (300) @(posedge i_clk);
    check_eq("abort_no_done", done_cnt, exp_done);
    send(8'hC3, 1);
    wait_done(400);
    check_eq("done_after_abort", done_cnt, exp_done);

`ifdef UART_TX_PARITY_EN
    send(8'h07, 1);
    wait_done(500);
    send(8'h03, 1);
    wait_done(500);
    check_eq("done_parity", done_cnt, exp_done);
`endif

    repeat (20) @(posedge i_clk);
    check_eq("scoreboard_empty", exp_q.size(), 0);
    check_eq("done_total", done_cnt, exp_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
